// File: rtl/dda_pkg.sv
// Shared constants and types for the DDA state framer.
package dda_pkg;

   localparam logic [7:0] DDA_SYNC_BYTE = 8'hA5;

   localparam int unsigned FRAME_LEN = 8;
   localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

   typedef enum logic {
      IDLE,
      SEND
   } framer_state_t;

   // Position of each field within the 8-byte frame.
   localparam logic [IDX_W-1:0] IDX_SYNC = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_X_HI = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_X_LO = IDX_W'(2);
   localparam logic [IDX_W-1:0] IDX_Y_HI = IDX_W'(3);
   localparam logic [IDX_W-1:0] IDX_Y_LO = IDX_W'(4);
   localparam logic [IDX_W-1:0] IDX_Z_HI = IDX_W'(5);
   localparam logic [IDX_W-1:0] IDX_Z_LO = IDX_W'(6);
   localparam logic [IDX_W-1:0] IDX_CSUM = IDX_W'(7);

endpackage

// File: rtl/dda_state_framer_if.sv
// Byte-stream valid/ready link from the framer to the UART transmitter.
interface dda_state_framer_if;

   logic [7:0] tx_byte;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_byte, output tx_valid, input tx_ready);
   modport slave  (input tx_byte, input tx_valid, output tx_ready);

endinterface

// File: rtl/dda_state_framer.sv
// Snapshots x/y/z on a decimated step strobe and streams each snapshot as
// an 8-byte frame (sync, x, y, z big-endian, XOR checksum) to the UART.
module dda_state_framer
   import dda_pkg::*;
#(
   parameter int unsigned N         = 16,
   parameter int unsigned DECIM_W   = 8,
   parameter logic [7:0]  SYNC_BYTE = DDA_SYNC_BYTE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sample_en,
   input  logic [N-1:0]       x,
   input  logic [N-1:0]       y,
   input  logic [N-1:0]       z,
   input  logic [DECIM_W-1:0] decim,
   dda_state_framer_if.master tx,
   output logic               busy,
   output logic               overrun,
   output logic [7:0]         drop_cnt
);

   framer_state_t      state;
   logic [IDX_W-1:0]   idx;
   logic [DECIM_W-1:0] dec_cnt;
   logic [N-1:0]       x_q;
   logic [N-1:0]       y_q;
   logic [N-1:0]       z_q;
   logic [7:0]         csum_q;

   logic               due;
   logic               xfer;
   logic               accept;
   logic [IDX_W-1:0]   idx_next;
   logic [7:0]         next_byte;
   logic [7:0]         snap_csum;

   // Capture decision, handshake detection and checksum of the live inputs.
   always_comb begin
      due       = sample_en && (dec_cnt >= decim);
      xfer      = tx.tx_valid && tx.tx_ready;
      // Back-to-back: a due capture may replace the frame whose checksum
      // byte is leaving this very cycle.
      accept    = due && ((state == IDLE) || (xfer && (idx == IDX_CSUM)));
      idx_next  = idx + 1'b1;
      snap_csum = x[N-1 -: 8] ^ x[7:0] ^ y[N-1 -: 8] ^ y[7:0] ^ z[N-1 -: 8] ^ z[7:0];
   end

   // Byte presented after the current index handshakes.
   always_comb begin
      next_byte = SYNC_BYTE;
      case (idx_next)
         IDX_SYNC: next_byte = SYNC_BYTE;
         IDX_X_HI: next_byte = x_q[N-1 -: 8];
         IDX_X_LO: next_byte = x_q[7:0];
         IDX_Y_HI: next_byte = y_q[N-1 -: 8];
         IDX_Y_LO: next_byte = y_q[7:0];
         IDX_Z_HI: next_byte = z_q[N-1 -: 8];
         IDX_Z_LO: next_byte = z_q[7:0];
         IDX_CSUM: next_byte = csum_q;
         default:  next_byte = SYNC_BYTE;
      endcase
   end

   // Decimation, drop accounting and the IDLE/SEND framer with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         dec_cnt    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         csum_q     <= '0;
         tx.tx_byte <= '0;
         tx.tx_valid <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         overrun <= 1'b0;

         if (due) begin
            dec_cnt <= '0;
         end else if (sample_en) begin
            dec_cnt <= dec_cnt + 1'b1;
         end

         if (due && !accept) begin
            overrun <= 1'b1;
            if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + 1'b1;
            end
         end

         if (accept) begin
            x_q         <= x;
            y_q         <= y;
            z_q         <= z;
            csum_q      <= snap_csum;
            idx         <= IDX_SYNC;
            tx.tx_byte  <= SYNC_BYTE;
            tx.tx_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= SEND;
         end else if (xfer) begin
            if (idx == IDX_CSUM) begin
               idx         <= '0;
               tx.tx_valid <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end else begin
               idx        <= idx_next;
               tx.tx_byte <= next_byte;
            end
         end
      end
   end

endmodule

// File: tb/tb_dda_state_framer.sv
// Self-checking bench for dda_state_framer: table of known frames, directed
// corner-case sequences and randomized traffic against a queue-based model.
module tb_dda_state_framer;

   logic        clk;
   logic        rst;
   logic        sample_en;
   logic [15:0] x;
   logic [15:0] y;
   logic [15:0] z;
   logic [7:0]  decim;
   logic        busy;
   logic        overrun;
   logic [7:0]  drop_cnt;

   dda_state_framer_if bus ();

   dda_state_framer #(.N(16), .DECIM_W(8), .SYNC_BYTE(8'hA5)) dut (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .x         (x),
      .y         (y),
      .z         (z),
      .decim     (decim),
      .tx        (bus),
      .busy      (busy),
      .overrun   (overrun),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: bytes still owed to the UART, strobes since reset,
   // expected overrun pulse and drop total.
   logic [7:0]  mq[$];
   int unsigned m_strobes;
   logic        m_ovr;
   int unsigned m_drop;

   // Bytes actually handed over by the DUT.
   logic [7:0]  sent[$];

   typedef struct {
      logic [15:0] vx;
      logic [15:0] vy;
      logic [15:0] vz;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[4];

   localparam logic [63:0] BASIC_FRAME = 64'hA5C0_0014_CD72_402B;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [15:0] fx, input logic [15:0] fy, input logic [15:0] fz);
      logic [7:0] cs;
      cs = fx[15:8] ^ fx[7:0] ^ fy[15:8] ^ fy[7:0] ^ fz[15:8] ^ fz[7:0];
      mq.push_back(8'hA5);
      mq.push_back(fx[15:8]);
      mq.push_back(fx[7:0]);
      mq.push_back(fy[15:8]);
      mq.push_back(fy[7:0]);
      mq.push_back(fz[15:8]);
      mq.push_back(fz[7:0]);
      mq.push_back(cs);
   endtask

   task automatic model_edge();
      if (rst) begin
         mq.delete();
         m_strobes = 0;
         m_ovr     = 1'b0;
         m_drop    = 0;
      end else begin
         m_ovr = 1'b0;
         if (mq.size() != 0 && bus.tx_ready) void'(mq.pop_front());
         if (sample_en) begin
            m_strobes++;
            if (m_strobes % (32'(decim) + 1) == 0) begin
               if (mq.size() == 0) begin
                  push_frame(x, y, z);
               end else begin
                  m_ovr = 1'b1;
                  if (m_drop < 255) m_drop++;
               end
            end
         end
      end
   endtask

   task automatic check_outputs();
      check("tx_valid", bus.tx_valid, mq.size() != 0);
      if (mq.size() != 0) check("tx_byte", bus.tx_byte, mq[0]);
      check("busy", busy, mq.size() != 0);
      check("overrun", overrun, m_ovr);
      check("drop_cnt", drop_cnt, 8'(m_drop));
   endtask

   // One clock: log a handshake, let the edge happen, update model, compare.
   task automatic cycle();
      if (bus.tx_valid && bus.tx_ready) sent.push_back(bus.tx_byte);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      sample_en = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic strobe(input logic [15:0] sx, input logic [15:0] sy, input logic [15:0] sz);
      x         = sx;
      y         = sy;
      z         = sz;
      sample_en = 1'b1;
      cycle();
      sample_en = 1'b0;
   endtask

   task automatic collect(input int n, input int budget);
      int c = 0;
      while (sent.size() < n && c < budget) begin
         cycle();
         c++;
      end
      check("collect_len", sent.size(), n);
   endtask

   task automatic check_frame(input string name, input logic [63:0] exp, input int base);
      for (int i = 0; i < 8; i++) begin
         check(name, (base + i < sent.size()) ? sent[base + i] : 8'hxx, exp[63 - 8*i -: 8]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'hC000, 16'h14CD, 16'h7240, BASIC_FRAME};
      vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 64'hA500_0000_0000_0000};
      vecs[2] = '{16'hFFFF, 16'h0000, 16'h1234, 64'hA5FF_FF00_0012_3426};
      vecs[3] = '{16'h0102, 16'h0408, 16'h1020, 64'hA501_0204_0810_203F};

      rst          = 1'b1;
      sample_en    = 1'b0;
      x            = '0;
      y            = '0;
      z            = '0;
      decim        = 8'd0;
      bus.tx_ready = 1'b1;
      m_strobes    = 0;
      m_ovr        = 1'b0;
      m_drop       = 0;

      // Reset state.
      do_reset();
      check("rst_valid", bus.tx_valid, 1'b0);
      check("rst_byte", bus.tx_byte, 8'h00);
      check("rst_drop", drop_cnt, 8'h00);

      // Table of known frames, full-rate drain.
      for (int v = 0; v < 4; v++) begin
         sent.delete();
         strobe(vecs[v].vx, vecs[v].vy, vecs[v].vz);
         check("tbl_first", bus.tx_byte, 8'hA5);
         collect(8, 20);
         check_frame("tbl_byte", vecs[v].exp, 0);
         check("tbl_idle", busy, 1'b0);
      end

      // Backpressure on the y high byte, inputs scrambled mid-frame.
      do_reset();
      sent.delete();
      strobe(16'hC000, 16'h14CD, 16'h7240);
      for (int i = 0; i < 3; i++) cycle();
      bus.tx_ready = 1'b0;
      x = 16'hDEAD;
      y = 16'hBEEF;
      z = 16'h5555;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("bp_hold_byte", bus.tx_byte, 8'h14);
         check("bp_hold_valid", bus.tx_valid, 1'b1);
      end
      bus.tx_ready = 1'b1;
      collect(8, 20);
      check_frame("bp_byte", BASIC_FRAME, 0);

      // Decimation: one frame per four strobes.
      decim = 8'd3;
      do_reset();
      sent.delete();
      for (int i = 1; i <= 8; i++) begin
         strobe(16'(32'h0101 * i), 16'h00FF, 16'h0000);
         for (int j = 0; j < 19; j++) cycle();
      end
      check("dec_len", sent.size(), 16);
      check_frame("dec_f1", 64'hA504_0400_FF00_00FF, 0);
      check_frame("dec_f2", 64'hA508_0800_FF00_00FF, 8);
      check("dec_drop", drop_cnt, 8'h00);

      // Overrun with a stalled UART, then saturation of the drop counter.
      decim = 8'd0;
      do_reset();
      bus.tx_ready = 1'b0;
      strobe(16'h1234, 16'h5678, 16'h9ABC);
      cycle();
      cycle();
      strobe(16'h1111, 16'h2222, 16'h3333);
      check("ovr_pulse", overrun, 1'b1);
      check("ovr_byte", bus.tx_byte, 8'hA5);
      check("ovr_drop", drop_cnt, 8'd1);
      cycle();
      check("ovr_clear", overrun, 1'b0);
      sample_en = 1'b1;
      for (int i = 0; i < 300; i++) cycle();
      sample_en = 1'b0;
      check("ovr_sat", drop_cnt, 8'd255);
      bus.tx_ready = 1'b1;

      // Back-to-back: second capture lands on the checksum handshake.
      do_reset();
      strobe(16'hC000, 16'h14CD, 16'h7240);
      for (int i = 0; i < 7; i++) begin
         cycle();
         check("b2b_busy", busy, 1'b1);
         check("b2b_no_ovr", overrun, 1'b0);
      end
      strobe(16'h1111, 16'h2222, 16'h3333);
      check("b2b_sync", bus.tx_byte, 8'hA5);
      check("b2b_busy2", busy, 1'b1);
      check("b2b_no_ovr2", overrun, 1'b0);
      sent.delete();
      collect(8, 20);
      check_frame("b2b_byte", 64'hA511_1122_2233_3300, 0);

      // Reset while the y low byte is presented.
      do_reset();
      strobe(16'hC000, 16'h14CD, 16'h7240);
      for (int i = 0; i < 4; i++) cycle();
      check("rmf_idx4", bus.tx_byte, 8'hCD);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("rmf_valid", bus.tx_valid, 1'b0);
      check("rmf_busy", busy, 1'b0);
      check("rmf_drop", drop_cnt, 8'h00);
      for (int i = 0; i < 3; i++) cycle();
      sent.delete();
      strobe(16'hC000, 16'h14CD, 16'h7240);
      collect(8, 20);
      check_frame("rmf_byte", BASIC_FRAME, 0);

      // Randomized traffic against the model.
      for (int r = 0; r < 4; r++) begin
         decim = 8'(r % 3);
         do_reset();
         for (int i = 0; i < 1500; i++) begin
            sample_en    = ($urandom_range(0, 3) == 0);
            bus.tx_ready = ($urandom_range(0, 9) < 7);
            x            = 16'($urandom);
            y            = 16'($urandom);
            z            = 16'($urandom);
            rst          = ($urandom_range(0, 499) == 0);
            cycle();
         end
         rst       = 1'b0;
         sample_en = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dda_state_framer.md
Name: dda_state_framer

Overview:
Downstream stage of the Lorenz posit DDA core.
- Snapshots the three N-bit state variables x, y, z on a decimated integration-step strobe.
- Serialises each snapshot into a fixed 8-byte frame: sync byte, six data bytes, XOR checksum.
- Presents bytes over a valid/ready interface to the UART transmitter, so host software can plot the attractor.

Parameters:
- N, 16, posit width of each state variable; must be 16 (two bytes per variable).
- DECIM_W, 8, width of the decimation control input.
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sample_en  in  1  one-cycle strobe: DDA completed a step; x/y/z valid this cycle.
- x  in  N  DDA state x.
- y  in  N  DDA state y.
- z  in  N  DDA state z.
- decim  in  DECIM_W  send one frame per decim+1 strobes (0 = every strobe).
- tx_byte  out  8  current frame byte.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  UART can accept a byte (not transmitting).
- busy  out  1  frame in flight (state != IDLE).
- overrun  out  1  one-cycle pulse: a due snapshot was dropped.
- drop_cnt  out  8  saturating count of dropped snapshots.

Behaviour:
- Single clock domain. Reset is synchronous, active high, and takes priority over all other inputs.
- Reset values:
  - tx_byte=0, tx_valid=0, busy=0, overrun=0, drop_cnt=0.
  - Decimation counter=0, state=IDLE, snapshot regs=0, byte index=0.
- Reset mid-frame aborts the frame; no partial bytes are emitted afterwards.
- Decimation:
  - Counter increments on each sample_en.
  - Capture is due when sample_en=1 and counter >= decim. The >= covers decim being lowered at runtime.
  - Counter returns to 0 when a capture is due, whether or not the snapshot is accepted.
- Capture:
  - A due capture is accepted if state=IDLE, or if the last frame byte (checksum) handshakes in the same cycle (back-to-back, no drop).
  - On acceptance: register {x,y,z}, compute checksum = x[15:8]^x[7:0]^y[15:8]^y[7:0]^z[15:8]^z[7:0] into a register, go to SEND with index 0.
- Drop:
  - A due capture that is not accepted raises overrun for exactly 1 cycle.
  - drop_cnt increments and saturates at 255.
  - The snapshot in flight is unaffected.
- FSM: IDLE -> SEND (on accepted capture); SEND -> IDLE after index 7 handshakes with no new capture; SEND -> SEND (index 0) on back-to-back capture.
- Byte order, index 0..7: SYNC_BYTE, x[15:8], x[7:0], y[15:8], y[7:0], z[15:8], z[7:0], checksum.
- Handshake:
  - A transfer occurs on a rising edge where tx_valid && tx_ready.
  - tx_valid, once high, stays high and tx_byte stays stable until the transfer.
  - Index advances only on a transfer.
  - tx_ready is ignored while tx_valid=0.
- Latency: accepted capture at edge k gives tx_valid=1 with tx_byte=SYNC_BYTE from edge k+1.
- Bandwidth: with tx_ready held high, one byte per cycle, so 8 cycles per frame.
- tx_valid=0 in IDLE. tx_byte holds its last value when tx_valid=0; consumers must not rely on it.
- x/y/z changes after capture do not affect the frame in flight.

Decomposition:
- Shared package dda_pkg holds:
  - DDA_SYNC_BYTE.
  - FRAME_LEN=8 and a byte-index width constant.
  - Framer state enum {IDLE, SEND}.
  - Byte-index constants for each frame field.
- Single module, no sub-module. The byte select is a simple case on the index.

Test Plan:
- Basic frame: decim=0, tx_ready=1, x=16'hC000, y=16'h14CD, z=16'h7240, one sample_en pulse -> from next cycle, bytes A5 C0 00 14 CD 72 40 2B on consecutive cycles; busy drops after the 8th; drop_cnt=0.
- Backpressure: basic frame, but tx_ready=0 for 5 cycles while index 3 is presented -> tx_byte holds 8'h14 with tx_valid=1 throughout; frame otherwise identical; x/y/z changed mid-frame has no effect.
- Decimation: decim=3, 8 sample_en pulses spaced 20 cycles apart with distinct x values -> exactly 2 frames, carrying the values from pulses 4 and 8; drop_cnt=0.
- Overrun: decim=0, tx_ready=0, sample_en at cycles 0 and 3 -> first frame holds A5; overrun pulses 1 cycle after the second strobe; drop_cnt=1. Then 300 further strobes -> drop_cnt saturates at 255.
- Back-to-back: decim=0, tx_ready=1, second sample_en coincides with the checksum handshake -> second frame's A5 on the very next cycle; busy never deasserts; no overrun.
- Reset mid-frame: assert rst for 1 cycle while index 4 is presented -> next cycle tx_valid=0, busy=0, drop_cnt=0; next strobe yields a complete frame starting with A5.
